// File: rtl/uart_ext_pkg.sv
// Shared encodings, error bit positions and FSM state types for the uart_ext serial port.
package uart_ext_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int ERR_OVR = 2;
    localparam int ERR_FRM = 1;
    localparam int ERR_PAR = 0;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // 2'b11 decodes as "no parity" just like 2'b00.
    function automatic logic parity_on(input logic [1:0] cfg);
        return (cfg == PAR_EVEN) || (cfg == PAR_ODD);
    endfunction

    function automatic logic [15:0] div_clamp(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Count-based ring FIFO with a combinational head; writes when full and reads when empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   rd,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/uart_ext.sv
// Full-duplex UART with runtime frame format, TX/RX FIFOs and per-byte RX error status.
module uart_ext
    import uart_ext_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 baud_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        tx_wr,
    input  logic [DATA_W-1:0]           tx_data,
    output logic                        tx_full,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic                        tx_busy,
    output logic                        tx_pin,
    input  logic                        rx_pin,
    input  logic                        rx_rd,
    output logic                        rx_valid,
    output logic [DATA_W-1:0]           rx_data,
    output logic [2:0]                  rx_err,
    output logic [$clog2(FIFO_DEPTH):0] rx_level
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    logic [15:0] baud_eff;
    assign baud_eff = div_clamp(baud_div);

    // ---------------- TX ----------------
    tx_state_t         tx_state;
    tx_state_t         tx_state_nxt;
    logic [15:0]       tx_cnt;
    logic [15:0]       tx_div;
    logic [3:0]        tx_bit;
    logic              tx_stop_idx;
    logic [1:0]        tx_par_cfg;
    logic              tx_stop2;
    logic [DATA_W-1:0] tx_shreg;
    logic              tx_par_bit;
    logic              tx_pop;
    logic              tx_empty;
    logic              tx_cnt_zero;
    logic [DATA_W-1:0] tx_head;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    assign tx_cnt_zero = (tx_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:   if (!tx_empty) tx_state_nxt = TX_START;
            TX_START:  if (tx_cnt_zero) tx_state_nxt = TX_DATA;
            TX_DATA:   if (tx_cnt_zero && tx_bit == LAST_BIT)
                           tx_state_nxt = parity_on(tx_par_cfg) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_cnt_zero) tx_state_nxt = TX_STOP;
            TX_STOP:   if (tx_cnt_zero && (tx_stop_idx || !tx_stop2)) tx_state_nxt = TX_IDLE;
            default:   tx_state_nxt = TX_IDLE;
        endcase
    end

    // tx_pin decodes straight from state so an async reset forces the line idle at once.
    always_comb begin
        tx_pin  = 1'b1;
        tx_pop  = 1'b0;
        tx_busy = (tx_state != TX_IDLE);
        case (tx_state)
            TX_IDLE:   tx_pop = !tx_empty;
            TX_START:  tx_pin = 1'b0;
            TX_DATA:   tx_pin = tx_shreg[0];
            TX_PARITY: tx_pin = tx_par_bit;
            default:   tx_pin = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt      <= '0;
            tx_div      <= 16'd2;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
            tx_par_cfg  <= PAR_NONE;
            tx_stop2    <= 1'b0;
        end else if (tx_pop) begin
            tx_cnt      <= baud_eff - 16'd1;
            tx_div      <= baud_eff;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
            tx_par_cfg  <= cfg_parity;
            tx_stop2    <= cfg_stop2;
        end else if (tx_state != TX_IDLE) begin
            if (tx_cnt_zero) begin
                tx_cnt <= tx_div - 16'd1;
                if (tx_state == TX_DATA)
                    tx_bit <= tx_bit + 4'd1;
                if (tx_state == TX_STOP)
                    tx_stop_idx <= 1'b1;
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop) begin
            tx_shreg   <= tx_head;
            tx_par_bit <= (^tx_head) ^ (cfg_parity == PAR_ODD);
        end else if (tx_state == TX_DATA && tx_cnt_zero) begin
            tx_shreg <= tx_shreg >> 1;
        end
    end

    // ---------------- RX ----------------
    logic              rx_meta;
    logic              rx_s;
    rx_state_t         rx_state;
    rx_state_t         rx_state_nxt;
    logic [15:0]       rx_cnt;
    logic [15:0]       rx_div;
    logic [3:0]        rx_bit;
    logic              rx_stop_idx;
    logic [1:0]        rx_par_cfg;
    logic              rx_stop2;
    logic [DATA_W-1:0] rx_shreg;
    logic              rx_perr;
    logic              rx_ferr;
    logic              ovr_sticky;
    logic              rx_start;
    logic              rx_push;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_cnt_zero;
    logic              rx_last_stop;
    logic [2:0]        rx_status;
    logic [DATA_W+2:0] rx_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
        end
    end

    assign rx_cnt_zero  = (rx_cnt == '0);
    assign rx_last_stop = rx_stop_idx || !rx_stop2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_s) rx_state_nxt = RX_START;
            RX_START:     if (rx_cnt_zero) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_cnt_zero && rx_bit == LAST_BIT)
                              rx_state_nxt = parity_on(rx_par_cfg) ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_cnt_zero) rx_state_nxt = RX_STOP;
            RX_STOP:      if (rx_cnt_zero && rx_last_stop) rx_state_nxt = RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) rx_state_nxt = RX_IDLE;
            default:      rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_start = (rx_state == RX_IDLE) && !rx_s;
        rx_push  = (rx_state == RX_STOP) && rx_cnt_zero && rx_last_stop;
    end

    // The final stop sample is folded in directly so the entry is pushed on that same edge.
    always_comb begin
        rx_status          = '0;
        rx_status[ERR_OVR] = ovr_sticky;
        rx_status[ERR_FRM] = rx_ferr | ~rx_s;
        rx_status[ERR_PAR] = rx_perr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt      <= '0;
            rx_div      <= 16'd2;
            rx_bit      <= '0;
            rx_stop_idx <= 1'b0;
            rx_par_cfg  <= PAR_NONE;
            rx_stop2    <= 1'b0;
            rx_perr     <= 1'b0;
            rx_ferr     <= 1'b0;
        end else if (rx_start) begin
            rx_cnt      <= (baud_eff >> 1) - 16'd1;
            rx_div      <= baud_eff;
            rx_bit      <= '0;
            rx_stop_idx <= 1'b0;
            rx_par_cfg  <= cfg_parity;
            rx_stop2    <= cfg_stop2;
            rx_perr     <= 1'b0;
            rx_ferr     <= 1'b0;
        end else if (rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH) begin
            if (rx_cnt_zero) begin
                rx_cnt <= rx_div - 16'd1;
                if (rx_state == RX_DATA)
                    rx_bit <= rx_bit + 4'd1;
                if (rx_state == RX_PARITY)
                    rx_perr <= rx_s ^ (^rx_shreg) ^ (rx_par_cfg == PAR_ODD);
                if (rx_state == RX_STOP) begin
                    rx_ferr     <= rx_ferr | ~rx_s;
                    rx_stop_idx <= 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_cnt_zero)
            rx_shreg <= {rx_s, rx_shreg[DATA_W-1:1]};
    end

    // Fullness is judged before any same-cycle pop, so a full FIFO always drops the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovr_sticky <= 1'b0;
        else if (rx_push)
            ovr_sticky <= rx_full;
    end

    uart_sync_fifo #(.WIDTH(DATA_W + 3), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push),
        .wdata ({rx_status, rx_shreg}),
        .rd    (rx_rd),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign rx_valid = !rx_empty;
    assign rx_data  = rx_head[DATA_W-1:0];
    assign rx_err   = rx_head[DATA_W+2:DATA_W];

endmodule

// File: tb/tb_uart_ext.sv
// Bench for uart_ext: directed stimulus, serial-line and RX-FIFO monitors fed from expectation queues.
module tb_uart_ext;

    logic        clk;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic [2:0]  tx_level;
    logic        tx_busy;
    logic        tx_pin;
    logic        rx_pin;
    logic        rx_rd;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [2:0]  rx_err;
    logic [2:0]  rx_level;

    logic        loop;
    logic        rx_drv;
    logic        tx_mon_en;
    int          rd_budget;
    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_tx[$];
    logic [10:0] exp_rx[$];

    assign rx_pin = loop ? tx_pin : rx_drv;

    uart_ext #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_level   (tx_level),
        .tx_busy    (tx_busy),
        .tx_pin     (tx_pin),
        .rx_pin     (rx_pin),
        .rx_rd      (rx_rd),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_level   (rx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        for (int k = 0; k < 400 && tx_full; k++) @(negedge clk);
        if (tx_mon_en) exp_tx.push_back(b);
        tx_wr   = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input int d);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (d) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    // Serial-line monitor: decodes frames on tx_pin with the configured format.
    initial begin : tx_monitor
        int         d;
        logic [7:0] b;
        logic [7:0] e;
        logic       pbit;
        forever begin
            @(negedge clk);
            if (tx_mon_en && rst && tx_pin == 1'b0) begin
                d = (baud_div < 2) ? 2 : int'(baud_div);
                repeat (d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx_pin;
                end
                if (cfg_parity == 2'b01 || cfg_parity == 2'b10) begin
                    repeat (d) @(negedge clk);
                    pbit = tx_pin;
                    chk("tx_parity", pbit, (^b) ^ (cfg_parity == 2'b10));
                end
                repeat (d) @(negedge clk);
                chk("tx_stop1", tx_pin, 1);
                if (cfg_stop2) begin
                    repeat (d) @(negedge clk);
                    chk("tx_stop2", tx_pin, 1);
                end
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got frame %0h, expected none", b);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_data", b, e);
                end
            end
        end
    end

    // RX FIFO monitor: pops entries while the stimulus grants a read budget.
    initial begin : rx_monitor
        logic [10:0] e;
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rd_budget > 0 && rx_valid) begin
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got %0h, expected none", {rx_err, rx_data});
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_entry", {rx_err, rx_data}, e);
                end
                rx_rd = 1'b1;
                rd_budget--;
            end else begin
                rx_rd = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [9:0] fb;
        n_checks   = 0;
        n_errors   = 0;
        rd_budget  = 0;
        rst        = 1'b0;
        baud_div   = 16'd4;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        tx_wr      = 1'b0;
        tx_data    = '0;
        loop       = 1'b0;
        rx_drv     = 1'b1;
        tx_mon_en  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tx_pin", tx_pin, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_level", rx_level, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 waveform of 0xA5 at 4 clocks per bit
        exp_tx.push_back(8'hA5);
        tx_wr   = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        tx_wr = 1'b0;
        chk("t1_level_after_wr", tx_level, 1);
        chk("t1_busy_before_pop", tx_busy, 0);
        chk("t1_pin_before_pop", tx_pin, 1);
        @(negedge clk);
        chk("t1_busy_after_pop", tx_busy, 1);
        chk("t1_level_after_pop", tx_level, 0);
        fb = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk("t1_pin_wave", tx_pin, fb[i / 4]);
            @(negedge clk);
        end
        chk("t1_busy_end", tx_busy, 0);
        chk("t1_pin_end", tx_pin, 1);
        repeat (10) @(negedge clk);

        // Loopback, even parity, two stop bits
        loop       = 1'b1;
        cfg_parity = 2'b01;
        cfg_stop2  = 1'b1;
        exp_rx.push_back({3'b000, 8'h00});
        exp_rx.push_back({3'b000, 8'hFF});
        exp_rx.push_back({3'b000, 8'h3C});
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h3C);
        for (int k = 0; k < 600 && rx_level != 3; k++) @(negedge clk);
        chk("t2_rx_level", rx_level, 3);
        rd_budget = 3;
        for (int k = 0; k < 50 && rx_level != 0; k++) @(negedge clk);
        chk("t2_rx_drained", rx_level, 0);
        for (int k = 0; k < 200 && tx_busy; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        loop = 1'b0;

        // TX FIFO overflow while the engine is busy
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        send_tx(8'h10);
        @(negedge clk);
        chk("t3_busy", tx_busy, 1);
        for (int i = 0; i < 5; i++) begin
            tx_wr   = 1'b1;
            tx_data = 8'(17 * (i + 1));
            @(negedge clk);
            if (i < 4) exp_tx.push_back(8'(17 * (i + 1)));
            if (i == 2) chk("t3_not_full_after_3", tx_full, 0);
            if (i == 3) chk("t3_full_after_4", tx_full, 1);
        end
        tx_wr = 1'b0;
        chk("t3_level_after_5", tx_level, 4);
        chk("t3_full_after_5", tx_full, 1);
        for (int k = 0; k < 600 && (tx_busy || tx_level != 0); k++) @(negedge clk);
        chk("t3_drained", {tx_busy, tx_level}, 0);
        repeat (10) @(negedge clk);
        chk("t3_tx_queue_empty", exp_tx.size(), 0);

        // Injected 0x55, odd parity with wrong parity bit and low stop bit
        cfg_parity = 2'b10;
        baud_div   = 16'd8;
        drive_bits({1'b0, 1'b0, 8'h55, 1'b0}, 11, 8);
        for (int k = 0; k < 50 && !rx_valid; k++) @(negedge clk);
        chk("t4_rx_valid", rx_valid, 1);
        exp_rx.push_back({3'b011, 8'h55});
        rd_budget = 1;
        for (int k = 0; k < 20 && rx_level != 0; k++) @(negedge clk);
        chk("t4_rx_drained", rx_level, 0);
        repeat (10) @(negedge clk);

        // Start glitch shorter than half a bit
        cfg_parity = 2'b00;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_glitch_level", rx_level, 0);
        chk("t5_glitch_valid", rx_valid, 0);

        // RX overrun: six frames into a four-entry FIFO
        baud_div = 16'd4;
        loop     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_rx.push_back({3'b000, 8'(8'hA1 + i)});
            send_tx(8'(8'hA1 + i));
        end
        for (int k = 0; k < 600 && (tx_busy || tx_level != 0); k++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("t6_rx_level_full", rx_level, 4);
        rd_budget = 1;
        for (int k = 0; k < 20 && rd_budget != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("t6_rx_level_after_rd", rx_level, 3);
        exp_rx.push_back({3'b100, 8'hA7});
        send_tx(8'hA7);
        for (int k = 0; k < 200 && rx_level != 4; k++) @(negedge clk);
        chk("t6_rx_level_a7", rx_level, 4);
        rd_budget = 4;
        for (int k = 0; k < 50 && rx_level != 0; k++) @(negedge clk);
        chk("t6_rx_drained", rx_level, 0);
        exp_rx.push_back({3'b000, 8'hA8});
        send_tx(8'hA8);
        for (int k = 0; k < 200 && rx_level != 1; k++) @(negedge clk);
        chk("t6_rx_level_a8", rx_level, 1);
        rd_budget = 1;
        for (int k = 0; k < 20 && rx_level != 0; k++) @(negedge clk);
        chk("t6_rx_final_drain", rx_level, 0);
        for (int k = 0; k < 200 && tx_busy; k++) @(negedge clk);
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of a data bit
        tx_mon_en = 1'b0;
        loop      = 1'b0;
        send_tx(8'h00);
        send_tx(8'h11);
        send_tx(8'h22);
        repeat (4) @(negedge clk);
        chk("t7_pre_pin", tx_pin, 0);
        chk("t7_pre_busy", tx_busy, 1);
        chk("t7_pre_level", tx_level, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_async_pin", tx_pin, 1);
        chk("t7_async_busy", tx_busy, 0);
        chk("t7_async_tx_level", tx_level, 0);
        chk("t7_async_tx_full", tx_full, 0);
        chk("t7_async_rx_level", rx_level, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t7_idle_after", {tx_busy, tx_pin}, 2'b01);

        chk("end_tx_queue", exp_tx.size(), 0);
        chk("end_rx_queue", exp_rx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
